lis_stream_sorter: RTL
======================

// Module: lis_stream_sorter
// PURPOSE
//  Parametrised next-generation linear insertion sorter (LIS) with ready/valid streams on both sides.
//  Collects a batch of DATA_W-bit elements from the input stream, keeping them sorted as they arrive.
//  Streams the sorted batch out, with out_last marking the final element.
//  Generalises the fixed 8-bit design: configurable width and depth, per-batch asc/desc mode,
//  batch framing on both sides, occupancy output. Sits between the pin-level stream adapters.
// PARAMETERS
//  DATA_W    8                        element/key width in bits
//  LIS_SIZE  16                       number of sorter cells = maximum batch length (>=2)
//  CNT_W     $clog2(LIS_SIZE+1)       occupancy counter width (derived, do not override)
// PORTS
//  clock           in   1        single clock, all logic on rising edge
//  reset           in   1        synchronous, active-high
//  in_ready        out  1        sorter accepts an element this cycle
//  in_valid        in   1        in_data valid
//  in_data         in   DATA_W   element
//  in_last         in   1        element ends the batch
//  out_ready       in   1        downstream accepts
//  out_valid       out  1        out_data valid
//  out_data        out  DATA_W   sorted element (cell 0)
//  out_last        out  1        out_data is last element of batch
//  cfg_descending  in   1        0 = ascending, 1 = descending; sampled per batch
//  count           out  CNT_W    cells currently occupied
//  busy            out  1        1 while in DRAIN
// BEHAVIOUR
//  Reset (reset=1 at a clock edge):
//   - state=FILL, all cell valid bits=0, cell data=0, count=0, mode=asc
//   - in_ready forced 0 while reset is high
//   - out_valid=0, out_last=0, out_data=0, busy=0
//   - applies mid-batch too: partial batch discarded, nothing emitted
//  Handshake: a transfer occurs when valid&&ready at a rising edge.
//   - in_data/in_last must be held until accepted
//   - out_* stays stable while out_valid&&!out_ready
//  FILL: in_ready=1, out_valid=0.
//   - On an accept, insert v=in_data in ONE cycle; it is visible in the cells next cycle.
//   - m[i] = !valid[i] | (mode ? v>c[i] : v<c[i]); m[-1]=0.
//   - Cell i next value: m[i] ? (m[i-1] ? c[i-1] : v) : c[i]. valid[count] <= 1, count++.
//   - Equal keys are stable: a new element is placed after existing equal elements.
//   - mode <= cfg_descending on an accept when count==0; the same-cycle element uses
//     cfg_descending directly. cfg changes mid-batch are ignored.
//   - Go to DRAIN after an accept with in_last=1, or an accept that makes count==LIS_SIZE.
//     Full is an implicit last; the next element starts a new batch.
//  DRAIN: in_ready=0, busy=1.
//   - out_valid = (count!=0); out_data=c[0]; out_last=(count==1).
//   - On an output transfer: cells shift toward 0 (c[i]<=c[i+1], top cell invalidated), count--.
//   - The transfer with out_last=1 returns to FILL. in_ready=1 on the next cycle.
//   - No overlap of fill and drain. First out_valid is the cycle after the last accept.
//   - Sustained throughput is 1 element/cycle in both phases.
//  count is registered and equals the number of valid cells. It never exceeds LIS_SIZE.
//  Comparisons are unsigned, full DATA_W. No arithmetic overflow is possible.
// STRUCTURE
//  Package lis_pkg:
//   - state enum {FILL, DRAIN}
//   - function lis_before(a, b, desc): 1 if a must precede b
//  Sub-module lis_cell (one per cell, generate loop).
//   - Holds data+valid.
//   - Computes m[i] from v, and takes the left-neighbour data/m for insertion.
//   - Takes the right-neighbour data for the drain shift.
//  Top level holds the FSM, count, mode latch and output muxing.
// TESTING
//  1. Reset, then stream 4,1,3,2 (last on 2), asc, out_ready=1.
//     -> out 1,2,3,4, out_last only on 4, in_ready=0 during output.
//  2. Same input with cfg_descending=1 at the first element.
//     -> out 4,3,2,1. Toggling cfg mid-batch has no effect.
//  3. LIS_SIZE=16 elements, no in_last.
//     -> DRAIN entered after 16th accept, sorted 16-element burst, out_last on 16th.
//     -> 17th element is accepted only after the drain.
//  4. Duplicates 5,5,2,5 plus out_ready toggled pseudo-randomly.
//     -> out 2,5,5,5. Output held stable while stalled. count decrements per transfer.
//  5. reset asserted after 3 of 6 elements.
//     -> count=0, out_valid never asserts. A following batch 9,7 sorts to 7,9.
//  6. Single-element batch 0xAA with in_last.
//     -> one output 0xAA with out_last=1, back to FILL next cycle.
//  Golden data: software sort of the same batch, compared transfer by transfer.

Source files
------------

// File: rtl/lis_pkg.sv
// Shared types and the ordering rule for the linear insertion sorter.
package lis_pkg;

  typedef enum logic {FILL, DRAIN} lis_state_e;

  // Widest key the ordering helper handles; callers zero-extend narrower keys.
  localparam int LIS_MAX_W = 64;

  // 1 when key a must be placed ahead of key b. Equal keys never precede, so
  // arrival order is kept among duplicates.
  function automatic logic lis_before(input logic [LIS_MAX_W-1:0] a,
                                      input logic [LIS_MAX_W-1:0] b,
                                      input logic desc);
    return desc ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/lis_cell.sv
// One sorter cell: holds a key, inserts in one cycle, shifts toward cell 0 on drain.
// No internal backpressure; the parent gates ins_en/shift_en with its handshakes.
module lis_cell
  import lis_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ins_en,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] ins_data,
  input  logic              desc,
  input  logic [DATA_W-1:0] left_data,
  input  logic              left_m,
  input  logic              left_valid,
  input  logic [DATA_W-1:0] right_data,
  input  logic              right_valid,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              m
);

  assign m = !valid || lis_before(LIS_MAX_W'(ins_data), LIS_MAX_W'(data), desc);

  // A cell becomes valid only when its left neighbour already was, which keeps
  // the occupied cells contiguous from cell 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (ins_en) begin
      if (m) begin
        data  <= left_m ? left_data : ins_data;
        valid <= valid | left_valid;
      end
    end else if (shift_en) begin
      data  <= right_data;
      valid <= right_valid;
    end
  end

endmodule

// File: rtl/lis_stream_sorter.sv
// Batch insertion sorter: fills sorted, then drains cell 0 first; first output the cycle after the last accept.
// in_ready low for the whole drain; out_* held while out_ready is low.
module lis_stream_sorter
  import lis_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LIS_SIZE = 16,
  parameter int CNT_W    = $clog2(LIS_SIZE + 1)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              in_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              cfg_descending,
  output logic [CNT_W-1:0]  count,
  output logic              busy
);

  logic [DATA_W-1:0]   c [LIS_SIZE];
  logic [LIS_SIZE-1:0] vld;
  logic [LIS_SIZE-1:0] m;
  lis_state_e          state, state_nxt;
  logic                mode;
  logic                ins_desc;
  logic                accept;
  logic                xfer;
  logic                unused_m_top;

  // The first element of a batch uses the live config; later ones the latched mode.
  assign ins_desc     = (count == '0) ? cfg_descending : mode;
  assign accept       = in_valid && in_ready;
  assign xfer         = out_valid && out_ready;
  assign unused_m_top = m[LIS_SIZE-1];

  for (genvar i = 0; i < LIS_SIZE; i++) begin : g_cell
    logic [DATA_W-1:0] left_data, right_data;
    logic              left_m, left_valid, right_valid;

    if (i == 0) begin : g_head
      assign left_data  = '0;
      assign left_m     = 1'b0;
      assign left_valid = 1'b1;
    end else begin : g_body
      assign left_data  = c[i-1];
      assign left_m     = m[i-1];
      assign left_valid = vld[i-1];
    end

    if (i == LIS_SIZE - 1) begin : g_tail
      assign right_data  = '0;
      assign right_valid = 1'b0;
    end else begin : g_inner
      assign right_data  = c[i+1];
      assign right_valid = vld[i+1];
    end

    lis_cell #(.DATA_W(DATA_W)) u_cell (
      .clock      (clock),
      .reset      (reset),
      .ins_en     (accept),
      .shift_en   (xfer),
      .ins_data   (in_data),
      .desc       (ins_desc),
      .left_data  (left_data),
      .left_m     (left_m),
      .left_valid (left_valid),
      .right_data (right_data),
      .right_valid(right_valid),
      .data       (c[i]),
      .valid      (vld[i]),
      .m          (m[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Reaching full is treated as an implicit end of batch.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:  if (accept && (in_last || count == CNT_W'(LIS_SIZE - 1))) state_nxt = DRAIN;
      DRAIN: if (xfer && out_last) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      FILL:  in_ready = !reset;
      DRAIN: begin
        busy      = 1'b1;
        out_valid = (count != '0);
      end
      default: ;
    endcase
    out_last = out_valid && (count == CNT_W'(1));
    out_data = out_valid ? c[0] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      mode  <= 1'b0;
    end else begin
      if (accept) begin
        count <= count + CNT_W'(1);
        if (count == '0) mode <= cfg_descending;
      end else if (xfer) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule
